// File: rtl/joystick_dir_decoder.sv
// joystick_dir_decoder: paces MCP3008 X/Y conversions, smooths each axis with a 4-sample
// moving average, and decodes a 5-way direction. Build option: JOY_AUTOREPEAT_EN adds auto-repeat.
//
// axis state | meaning
// AX_ZERO    | axis inside the dead-zone
// AX_POS     | axis deflected positive (right / up)
// AX_NEG     | axis deflected negative (left / down)
module joystick_dir_decoder #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int CENTER       = 512,
  parameter int DEADZONE     = 128,
  parameter int HYST         = 16,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic       adc_start,
  input  logic [9:0] adc_x,
  input  logic [9:0] adc_y,
  input  logic       adc_valid,
  output logic [9:0] x_avg,
  output logic [9:0] y_avg,
  output logic [2:0] dir,
  output logic       dir_event,
  output logic       overrun
);

  localparam int CW = $clog2(SAMPLE_DIV);

  localparam logic [2:0] DIR_C = 3'd0;
  localparam logic [2:0] DIR_U = 3'd1;
  localparam logic [2:0] DIR_D = 3'd2;
  localparam logic [2:0] DIR_L = 3'd3;
  localparam logic [2:0] DIR_R = 3'd4;

  localparam logic signed [10:0] TH_ENT = 11'(DEADZONE);
  localparam logic signed [10:0] TH_REL = 11'(DEADZONE - HYST);
  localparam logic signed [10:0] CTR    = 11'(CENTER);

  if (SAMPLE_DIV < 4 || HYST < 0 || HYST >= DEADZONE || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_param_check
    $error("joystick_dir_decoder: illegal parameter set");
  end

  typedef enum logic [1:0] {
    AX_ZERO = 2'b00,
    AX_POS  = 2'b01,
    AX_NEG  = 2'b10
  } axis_t;

  function automatic axis_t axis_next(input axis_t st, input logic signed [10:0] d);
    axis_t nx;
    nx = st;
    case (st)
      AX_ZERO: if (d > TH_ENT) nx = AX_POS; else if (d < -TH_ENT) nx = AX_NEG;
      AX_POS:  if (d < -TH_ENT) nx = AX_NEG; else if (d < TH_REL) nx = AX_ZERO;
      AX_NEG:  if (d > TH_ENT) nx = AX_POS; else if (d > -TH_REL) nx = AX_ZERO;
      default: nx = AX_ZERO;
    endcase
    return nx;
  endfunction

  // ---------------- pacer ----------------
  logic [CW-1:0] cnt;
  logic          busy;
  logic          tc;

  assign tc = (cnt == CW'(SAMPLE_DIV - 1));
  // A valid arriving on the terminal-count cycle frees the slot for this start.
  assign adc_start = tc && (!busy || adc_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (adc_start)
        busy <= 1'b1;
      else if (adc_valid)
        busy <= 1'b0;
      if (tc && busy && !adc_valid)
        overrun <= 1'b1;
    end
  end

  // ---------------- moving-average filter ----------------
  logic [9:0]  hx [4];
  logic [9:0]  hy [4];
  logic [11:0] sum_x, sum_y;
  logic [11:0] sum_x_nxt, sum_y_nxt;
  logic [2:0]  fill;
  logic        acc_q;

  assign sum_x_nxt = sum_x + 12'(adc_x) - 12'(hx[3]);
  assign sum_y_nxt = sum_y + 12'(adc_y) - 12'(hy[3]);
  assign x_avg     = sum_x[11:2];
  assign y_avg     = sum_y[11:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hx[i] <= '0;
        hy[i] <= '0;
      end
      sum_x <= '0;
      sum_y <= '0;
      fill  <= '0;
      acc_q <= 1'b0;
    end else begin
      acc_q <= adc_valid;
      if (adc_valid) begin
        sum_x <= sum_x_nxt;
        sum_y <= sum_y_nxt;
        hx[0] <= adc_x;
        hy[0] <= adc_y;
        for (int i = 1; i < 4; i++) begin
          hx[i] <= hx[i-1];
          hy[i] <= hy[i-1];
        end
        if (fill != 3'd4)
          fill <= fill + 3'd1;
      end
    end
  end

  // ---------------- direction decode ----------------
  logic signed [10:0] dx, dy;
  logic [10:0]        abs_x, abs_y;
  axis_t              ax_x, ax_y, ax_x_nxt, ax_y_nxt;
  logic [2:0]         dir_nxt;

  assign dx       = $signed({1'b0, x_avg}) - CTR;
  assign dy       = $signed({1'b0, y_avg}) - CTR;
  assign abs_x    = dx[10] ? -dx : dx;
  assign abs_y    = dy[10] ? -dy : dy;
  assign ax_x_nxt = axis_next(ax_x, dx);
  assign ax_y_nxt = axis_next(ax_y, dy);

  // Diagonal: larger deflection wins, X on a tie.
  always_comb begin
    dir_nxt = DIR_C;
    if (ax_x_nxt != AX_ZERO && (ax_y_nxt == AX_ZERO || abs_x >= abs_y))
      dir_nxt = (ax_x_nxt == AX_POS) ? DIR_R : DIR_L;
    else if (ax_y_nxt != AX_ZERO)
      dir_nxt = (ax_y_nxt == AX_POS) ? DIR_U : DIR_D;
  end

`ifdef JOY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_x      <= AX_ZERO;
      ax_y      <= AX_ZERO;
      dir       <= DIR_C;
      dir_event <= 1'b0;
`ifdef JOY_AUTOREPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      dir_event <= 1'b0;
      if (acc_q && fill == 3'd4) begin
        ax_x <= ax_x_nxt;
        ax_y <= ax_y_nxt;
        dir  <= dir_nxt;
        if (dir_nxt == DIR_C) begin
`ifdef JOY_AUTOREPEAT_EN
          rpt <= '0;
`endif
        end else if (dir_nxt != dir) begin
          dir_event <= 1'b1;
`ifdef JOY_AUTOREPEAT_EN
          rpt       <= RW'(REPEAT_DELAY);
`endif
        end
`ifdef JOY_AUTOREPEAT_EN
        else if (rpt == RW'(1)) begin
          dir_event <= 1'b1;
          rpt       <= RW'(REPEAT_RATE);
        end else if (rpt != '0) begin
          rpt <= rpt - RW'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_joystick_dir_decoder.sv
// Self-checking bench for joystick_dir_decoder: pacing/overrun, vector table driven through a
// scoreboard, and a reset-during-conversion sequence.
module tb_joystick_dir_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_start;
  logic [9:0] adc_x, adc_y;
  logic       adc_valid;
  logic [9:0] x_avg, y_avg;
  logic [2:0] dir;
  logic       dir_event;
  logic       overrun;

  joystick_dir_decoder #(
    .SAMPLE_DIV(16), .CENTER(512), .DEADZONE(128), .HYST(16),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .adc_start(adc_start), .adc_x(adc_x), .adc_y(adc_y),
    .adc_valid(adc_valid), .x_avg(x_avg), .y_avg(y_avg), .dir(dir),
    .dir_event(dir_event), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_before;
    int x, y, xa, ya, d, ev_rep, ev_norep;
  } vec_t;

  typedef struct {
    int xa, ya, d, ev;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic add(input bit r, input int x, input int y, input int xa, input int ya,
                     input int d, input int er, input int en);
    vec_t v;
    v.rst_before = r; v.x = x; v.y = y; v.xa = xa; v.ya = ya;
    v.d = d; v.ev_rep = er; v.ev_norep = en;
    vt.push_back(v);
  endtask

  function automatic int pick_ev(input int er, input int en);
`ifdef JOY_AUTOREPEAT_EN
    return er;
`else
    return en;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    adc_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on the negedge where adc_start is high; answers 5 cycles later.
  task automatic respond(input int x, input int y, input int xa, input int ya,
                         input int d, input int ev);
    exp_t e;
    repeat (5) @(negedge clk);
    adc_x = 10'(x);
    adc_y = 10'(y);
    adc_valid = 1'b1;
    e.xa = xa; e.ya = ya; e.d = d; e.ev = ev;
    sb.push_back(e);
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(output int k);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (adc_start) break;
    end
    if (k > 40) chk("start_timeout", 0, 1);
  endtask

  task automatic send(input int x, input int y, input int xa, input int ya,
                      input int d, input int ev);
    int k;
    wait_start(k);
    respond(x, y, xa, ya, d, ev);
  endtask

  // Scoreboard checker: avg one cycle after valid, dir/event the cycle after.
  initial begin
    forever begin
      @(posedge clk);
      if (adc_valid && !rst) begin
        #1;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("x_avg", int'(x_avg), cur.xa);
          chk("y_avg", int'(y_avg), cur.ya);
          chk("dir_early", int'(dir_event), 0);
          @(posedge clk);
          #1;
          chk("dir", int'(dir), cur.d);
          chk("dir_event", int'(dir_event), cur.ev);
          chk("overrun_clr", int'(overrun), 0);
          @(posedge clk);
          #1;
          chk("event_1cyc", int'(dir_event), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    adc_valid = 1'b0;
    adc_x = '0;
    adc_y = '0;

    // test 2: fill and average
    add(1, 1000, 512,  250, 128, 0, 0, 0);
    add(0, 1000, 512,  500, 256, 0, 0, 0);
    add(0, 1000, 512,  750, 384, 0, 0, 0);
    add(0, 1000, 512, 1000, 512, 4, 1, 1);
    add(0, 1000, 512, 1000, 512, 4, 0, 0);
    // test 3: hysteresis (enter at d=129, hold at 118/113, release at 108, d=128 not enough)
    add(1, 512, 512, 128, 128, 0, 0, 0);
    add(0, 512, 512, 256, 256, 0, 0, 0);
    add(0, 512, 512, 384, 384, 0, 0, 0);
    add(0, 512, 512, 512, 512, 0, 0, 0);
    add(0, 641, 512, 544, 512, 0, 0, 0);
    add(0, 641, 512, 576, 512, 0, 0, 0);
    add(0, 641, 512, 608, 512, 0, 0, 0);
    add(0, 641, 512, 641, 512, 4, 1, 1);
    add(0, 620, 512, 635, 512, 4, 0, 0);
    add(0, 620, 512, 630, 512, 4, 0, 0);
    add(0, 620, 512, 625, 512, 4, 0, 0);
    add(0, 620, 512, 620, 512, 0, 0, 0);
    add(0, 700, 512, 640, 512, 0, 0, 0);
    add(0, 700, 512, 660, 512, 4, 1, 1);
    // test 4: diagonal tie -> X, then larger Y wins
    add(1, 700, 700, 175, 175, 0, 0, 0);
    add(0, 700, 700, 350, 350, 0, 0, 0);
    add(0, 700, 700, 525, 525, 0, 0, 0);
    add(0, 700, 700, 700, 700, 4, 1, 1);
    add(0, 700, 750, 700, 712, 1, 1, 1);
    add(0, 700, 750, 700, 725, 1, 0, 0);
    // down, back through centre, then up
    add(1, 512,    0, 128,   0, 0, 0, 0);
    add(0, 512,    0, 256,   0, 0, 0, 0);
    add(0, 512,    0, 384,   0, 0, 0, 0);
    add(0, 512,    0, 512,   0, 2, 1, 1);
    add(0, 512, 1023, 512, 255, 2, 0, 0);
    add(0, 512, 1023, 512, 511, 0, 0, 0);
    add(0, 512, 1023, 512, 767, 1, 1, 1);
    // test 5: auto-repeat on held left
    add(1, 0, 512, 0, 128, 0, 0, 0);
    add(0, 0, 512, 0, 256, 0, 0, 0);
    add(0, 0, 512, 0, 384, 0, 0, 0);
    add(0, 0, 512, 0, 512, 3, 1, 1);
    add(0, 0, 512, 0, 512, 3, 0, 0);
    add(0, 0, 512, 0, 512, 3, 0, 0);
    add(0, 0, 512, 0, 512, 3, 0, 0);
    add(0, 0, 512, 0, 512, 3, 1, 0);
    add(0, 0, 512, 0, 512, 3, 0, 0);
    add(0, 0, 512, 0, 512, 3, 1, 0);
    add(0, 0, 512, 0, 512, 3, 0, 0);
    add(0, 0, 512, 0, 512, 3, 1, 0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", int'(adc_start), 0);
    chk("rst_outs", int'({x_avg, y_avg, dir, dir_event}), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;

    // test 1: pacing with no driver response
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t1_start_%0d", n), int'(adc_start), (n == 15) ? 1 : 0);
      chk($sformatf("t1_ovr_%0d", n), int'(overrun), (n >= 32) ? 1 : 0);
      chk("t1_quiet", int'({x_avg, y_avg, dir, dir_event}), 0);
    end

    // vector table
    foreach (vt[i]) begin
      if (vt[i].rst_before) do_reset();
      send(vt[i].x, vt[i].y, vt[i].xa, vt[i].ya, vt[i].d,
           pick_ev(vt[i].ev_rep, vt[i].ev_norep));
    end

    // test 6: reset between adc_start and adc_valid, then a late valid
    wait_start(k);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_dir", int'(dir), 0);
    chk("t6_avg", int'({x_avg, y_avg}), 0);
    chk("t6_start_evt_ovr", int'({adc_start, dir_event, overrun}), 0);
    @(negedge clk);
    rst = 1'b0;
    adc_x = 10'd1000;
    adc_y = 10'd512;
    adc_valid = 1'b1;
    cur.xa = 250; cur.ya = 128; cur.d = 0; cur.ev = 0;
    sb.push_back(cur);
    @(negedge clk);
    adc_valid = 1'b0;
    // the cycle count includes the negedge just consumed
    wait_start(k);
    chk("t6_first_start", k + 1, 15);
    chk("t6_overrun", int'(overrun), 0);
    respond(1000, 512, 500, 256, 0, 0);
    send(1000, 512, 750, 384, 0, 0);
    send(1000, 512, 1000, 512, 4, 1);
    chk("t6_overrun_end", int'(overrun), 0);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
